mem_port_arbiter: RTL and testbench

- Shares the single physical memory controller port between the instruction-fetch requester and the data (load/store) requester.
- Sits between the MMU's two translated access paths and the physical memory controller.
- Data accesses have fixed priority, bounded by an anti-starvation counter so fetch always makes progress.
- A watchdog aborts transactions the controller never acknowledges.

---
 rtl/mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one physical memory controller port between the instruction-fetch
// requester (i_*) and the data load/store requester (d_*).
// Data has fixed priority. A burst counter forces a pending fetch through
// after MAX_DATA_BURST consecutive data grants. A watchdog aborts any
// transaction that the controller does not acknowledge within TIMEOUT cycles.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   i_req/i_addr         fetch request (level) and address
//   i_rdata/i_done/i_err fetch completion: data, one-cycle pulse, timeout flag
//   d_req/d_addr/d_wdata/d_is_write
//                        data request (level), address, store data, direction
//   d_rdata/d_done/d_err data completion: data, one-cycle pulse, timeout flag
//   dev_mem_*            registered request to the memory controller
//   dev_mem_data_in/ack  controller read data and one-cycle completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_is_write,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        dev_mem_req,
  output logic [31:0] dev_mem_addr,
  output logic [31:0] dev_mem_data_out,
  output logic        dev_mem_is_write,
  input  logic [31:0] dev_mem_data_in,
  input  logic        dev_mem_ack
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0]       BURST_MAX = BW'(MAX_DATA_BURST);
  localparam logic [BW-1:0]       BURST_ONE = BW'(1);
  localparam logic [TO_WIDTH-1:0] TO_LAST   = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] TO_ONE    = TO_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BW-1:0]       r_burst_cnt, w_burst_nxt;
  logic [TO_WIDTH-1:0] r_to_cnt,    w_to_nxt;

  logic        r_i_done, r_i_err, r_d_done, r_d_err;
  logic [31:0] r_i_rdata, r_d_rdata;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;

  logic        w_i_done, w_i_err, w_d_done, w_d_err;
  logic [31:0] w_i_rdata, w_d_rdata;
  logic        w_mem_req, w_mem_we;
  logic [31:0] w_mem_addr, w_mem_wdata;

  logic w_idle, w_busy, w_burst_full, w_grant_d, w_grant_i;
  logic w_to_hit, w_finish, w_abort;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_busy       = !w_idle;
  assign w_burst_full = (r_burst_cnt >= BURST_MAX);
  // Data wins unless a fetch is waiting and the data burst allowance is spent.
  assign w_grant_d    = w_idle && d_req && (!i_req || !w_burst_full);
  assign w_grant_i    = w_idle && i_req && !w_grant_d;
  // This busy cycle is the TIMEOUT-th one; an ack in it still wins.
  assign w_to_hit     = (r_to_cnt == TO_LAST);
  assign w_finish     = w_busy && (dev_mem_ack || w_to_hit);
  assign w_abort      = w_busy && !dev_mem_ack && w_to_hit;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, leave BUSY on ack or timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_BUSY_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_BUSY_I;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (w_finish) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values: grant latching, counters, completion.
  always_comb begin
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_burst_nxt = r_burst_cnt;
    w_to_nxt    = r_to_cnt;
    w_i_done    = 1'b0;
    w_i_err     = 1'b0;
    w_i_rdata   = r_i_rdata;
    w_d_done    = 1'b0;
    w_d_err     = 1'b0;
    w_d_rdata   = r_d_rdata;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_mem_req   = 1'b1;
          w_mem_we    = d_is_write;
          w_mem_addr  = d_addr;
          w_mem_wdata = d_wdata;
          w_to_nxt    = '0;
          if (!i_req) begin
            w_burst_nxt = '0;
          end else if (w_burst_full) begin
            w_burst_nxt = r_burst_cnt;
          end else begin
            w_burst_nxt = r_burst_cnt + BURST_ONE;
          end
        end else if (w_grant_i) begin
          w_mem_req   = 1'b1;
          w_mem_we    = 1'b0;
          w_mem_addr  = i_addr;
          w_mem_wdata = 32'h0000_0000;
          w_to_nxt    = '0;
          w_burst_nxt = '0;
        end else begin
          w_mem_req = 1'b0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (w_finish) begin
          w_mem_req = 1'b0;
          w_to_nxt  = '0;
          if (r_state == ST_BUSY_I) begin
            w_i_done  = 1'b1;
            w_i_err   = w_abort;
            w_i_rdata = w_abort ? 32'h0000_0000 : dev_mem_data_in;
          end else begin
            w_d_done  = 1'b1;
            w_d_err   = w_abort;
            w_d_rdata = w_abort ? 32'h0000_0000 : dev_mem_data_in;
          end
        end else begin
          w_to_nxt = r_to_cnt + TO_ONE;
        end
      end
      default: begin
        w_mem_req = 1'b0;
        w_to_nxt  = '0;
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_burst_cnt <= '0;
      r_to_cnt    <= '0;
      r_i_done    <= 1'b0;
      r_i_err     <= 1'b0;
      r_i_rdata   <= 32'h0000_0000;
      r_d_done    <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= 32'h0000_0000;
    end else begin
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_burst_cnt <= w_burst_nxt;
      r_to_cnt    <= w_to_nxt;
      r_i_done    <= w_i_done;
      r_i_err     <= w_i_err;
      r_i_rdata   <= w_i_rdata;
      r_d_done    <= w_d_done;
      r_d_err     <= w_d_err;
      r_d_rdata   <= w_d_rdata;
    end
  end

  assign dev_mem_req      = r_mem_req;
  assign dev_mem_addr     = r_mem_addr;
  assign dev_mem_data_out = r_mem_wdata;
  assign dev_mem_is_write = r_mem_we;
  assign i_done           = r_i_done;
  assign i_err            = r_i_err;
  assign i_rdata          = r_i_rdata;
  assign d_done           = r_d_done;
  assign d_err            = r_d_err;
  assign d_rdata          = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_is_write = 1'b0;
  logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
  logic [31:0] i_rdata, d_rdata;
  logic        i_done, i_err, d_done, d_err;
  logic        dev_mem_req, dev_mem_is_write;
  logic [31:0] dev_mem_addr, dev_mem_data_out;
  logic [31:0] dev_mem_data_in = 32'h0;
  logic        ctl_ack = 1'b0, spur_ack = 1'b0;
  logic        dev_mem_ack;

  assign dev_mem_ack = ctl_ack | spur_ack;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_is_write(d_is_write),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .dev_mem_req(dev_mem_req), .dev_mem_addr(dev_mem_addr),
    .dev_mem_data_out(dev_mem_data_out), .dev_mem_is_write(dev_mem_is_write),
    .dev_mem_data_in(dev_mem_data_in), .dev_mem_ack(dev_mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  resp_t  exp_resp[$];
  grant_t exp_grant[$];

  int n_vec  = 0;
  int n_miss = 0;
  int done_cnt = 0;

  // controller model settings
  int          ctl_delay = 0;
  bit          ctl_noack = 1'b0;
  logic [31:0] ctl_data  = 32'h0;
  int          req_cycles = 0;
  int          last_len = 0;
  grant_t      cur_grant;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory controller model: checks each grant, holds stable, acks after delay.
  always @(negedge clk) begin
    ctl_ack = 1'b0;
    if (dev_mem_req) begin
      req_cycles++;
      if (req_cycles == 1) begin
        if (exp_grant.size() == 0) begin
          check("unexpected_grant", {32'h0, dev_mem_addr}, 64'h0);
          cur_grant = '{dev_mem_is_write, dev_mem_addr, dev_mem_data_out};
        end else begin
          cur_grant = exp_grant.pop_front();
        end
      end
      check("grant_addr", {31'h0, dev_mem_is_write, dev_mem_addr},
            {31'h0, cur_grant.we, cur_grant.addr});
      check("grant_wdata", {32'h0, dev_mem_data_out}, {32'h0, cur_grant.wdata});
      if (!ctl_noack && req_cycles == ctl_delay + 1) begin
        ctl_ack = 1'b1;
        dev_mem_data_in = ctl_data;
      end
    end else begin
      if (req_cycles != 0) last_len = req_cycles;
      req_cycles = 0;
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    resp_t e;
    if (i_done && d_done) check("both_done", 64'h1, 64'h0);
    if (i_done || d_done) begin
      done_cnt++;
      if (exp_resp.size() == 0) begin
        check("unexpected_done", {62'h0, i_done, d_done}, 64'h0);
      end else begin
        e = exp_resp.pop_front();
        if (d_done)
          check("d_resp", {30'h0, 1'b1, d_err, d_rdata}, {30'h0, e.is_d, e.err, e.rdata});
        else
          check("i_resp", {30'h0, 1'b0, i_err, i_rdata}, {30'h0, e.is_d, e.err, e.rdata});
      end
    end
  end

  task automatic do_access(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit we, input int delay, input bit noack,
                           input logic [31:0] data, input bit exp_err,
                           input logic [31:0] exp_rd);
    bit seen = 1'b0;
    ctl_delay = delay;
    ctl_noack = noack;
    ctl_data  = data;
    exp_grant.push_back(is_d ? grant_t'{we, addr, wdata} : grant_t'{1'b0, addr, 32'h0});
    exp_resp.push_back(resp_t'{is_d, exp_err, exp_rd});
    if (is_d) begin
      d_addr = addr; d_wdata = wdata; d_is_write = we; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (is_d ? d_done : i_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 64'h0, 64'h1);
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
  endtask

  initial begin
    int rises;
    bit prev;
    int dc;
    // reset state
    #12;
    check("rst_req", {63'h0, dev_mem_req}, 64'h0);
    check("rst_outs", {i_rdata, d_rdata} | {dev_mem_addr, dev_mem_data_out}, 64'h0);
    check("rst_flags", {58'h0, i_done, i_err, d_done, d_err, dev_mem_is_write, dev_mem_req}, 64'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // single load, ack two cycles after req
    do_access(1'b1, 32'h8000_1000, 32'h0, 1'b0, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    // store
    do_access(1'b1, 32'h8000_0010, 32'h1234_5678, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0);

    // contention: D,D,D,D,I,D,D,D,D,I
    ctl_delay = 0; ctl_noack = 1'b0; ctl_data = 32'hCAFE_0001;
    for (int g = 0; g < 10; g++) begin
      if (g == 4 || g == 9) begin
        exp_grant.push_back(grant_t'{1'b0, 32'h1000_0000, 32'h0});
        exp_resp.push_back(resp_t'{1'b0, 1'b0, 32'hCAFE_0001});
      end else begin
        exp_grant.push_back(grant_t'{1'b0, 32'h2000_0000, 32'h0});
        exp_resp.push_back(resp_t'{1'b1, 1'b0, 32'hCAFE_0001});
      end
    end
    i_addr = 32'h1000_0000; d_addr = 32'h2000_0000; d_wdata = 32'h0; d_is_write = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (dev_mem_req && !prev) rises++;
      prev = dev_mem_req;
      if (rises == 10) break;
    end
    check("contention_grants", rises, 10);
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk); #1;

    // fetch timeout, controller silent
    do_access(1'b0, 32'h1FC0_0000, 32'h0, 1'b0, 0, 1'b1, 32'h0, 1'b1, 32'h0);
    @(negedge clk); #1;
    check("timeout_req_len", last_len, 255);
    check("d_rdata_hold", {32'h0, d_rdata}, {32'h0, 32'hCAFE_0001});
    // data served normally afterwards
    do_access(1'b1, 32'h8000_2000, 32'h0, 1'b0, 1, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D);
    // ack on the last allowed cycle wins over the timeout
    do_access(1'b0, 32'h0040_0000, 32'h0, 1'b0, 254, 1'b0, 32'h600D_CAFE, 1'b0, 32'h600D_CAFE);
    @(negedge clk); #1;
    check("edge_req_len", last_len, 255);

    // spurious ack while idle
    dc = done_cnt;
    @(negedge clk); spur_ack = 1'b1;
    @(negedge clk); spur_ack = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("spurious_done", done_cnt, dc);
    check("spurious_req", {63'h0, dev_mem_req}, 64'h0);

    // reset during BUSY_D
    ctl_noack = 1'b1;
    exp_grant.push_back(grant_t'{1'b0, 32'h8000_3000, 32'h0});
    d_addr = 32'h8000_3000; d_wdata = 32'h0; d_is_write = 1'b0; d_req = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_req", {63'h0, dev_mem_req}, 64'h0);
    check("rst_mid_outs", {i_rdata, d_rdata} | {dev_mem_addr, dev_mem_data_out}, 64'h0);
    check("rst_mid_flags", {58'h0, i_done, i_err, d_done, d_err, dev_mem_is_write, dev_mem_req}, 64'h0);
    dc = done_cnt;
    d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("rst_no_done", done_cnt, dc);

    // normal traffic after reset
    do_access(1'b1, 32'h8000_4000, 32'h0, 1'b0, 0, 1'b0, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF);
    repeat (3) @(posedge clk); #1;
    check("resp_queue_empty", exp_resp.size(), 0);
    check("grant_queue_empty", exp_grant.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
